// File: rtl/tile_stream_frame_collector.sv
// tile_stream_frame_collector: assembles valid/ready tiles into ping-pong frame banks read by address
module tile_stream_frame_collector #(
  parameter int TILE_SIZE = 4,
  parameter int DATA_WIDTH = 16,
  parameter int D = 256,
  parameter int NTILE = D / TILE_SIZE,
  parameter int TA_W = $clog2(NTILE)
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] in_vec,
  output logic frame_done,
  output logic frame_valid,
  input  logic rd_en,
  input  logic [TA_W-1:0] rd_addr,
  output logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] rd_vec,
  input  logic frame_release,
  output logic [15:0] frame_cnt
);
  typedef enum logic [1:0] {FREE, FILLING, FULL} bank_t;
  bank_t st [2];
  bank_t st_n [2];
  logic wr_sel, rd_sel, acc, last, rel;
  logic [TA_W-1:0] wr_tile;
  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] mem [2][NTILE];
  assign in_ready = !rst && st[wr_sel] != FULL;
  assign frame_valid = st[rd_sel] == FULL;
  assign acc = in_valid && in_ready;
  assign last = acc && wr_tile == TA_W'(NTILE - 1);
  assign rel = frame_release && frame_valid;
  // write and release always target different banks: the released bank is FULL, the written one is not
  always_comb begin
    st_n = st;
    if (acc) st_n[wr_sel] = last ? FULL : FILLING;
    if (rel) st_n[rd_sel] = FREE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= '{FREE, FREE};
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_tile <= '0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
      rd_vec <= '0;
    end else begin
      st <= st_n;
      wr_sel <= wr_sel ^ last;
      rd_sel <= rd_sel ^ rel;
      wr_tile <= last ? '0 : acc ? wr_tile + TA_W'(1) : wr_tile;
      frame_done <= last;
      frame_cnt <= frame_cnt + {15'b0, last};
      if (rd_en) rd_vec <= mem[rd_sel][rd_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (acc) mem[wr_sel][wr_tile] <= in_vec;
  end
endmodule

// File: tb/tb_tile_stream_frame_collector.sv
// tb_tile_stream_frame_collector: scoreboard-based bench for the tile-to-frame ping-pong collector
module tb_tile_stream_frame_collector;
  localparam int TS = 4, DW = 16, DD = 256, NT = DD / TS, AW = $clog2(NT);
  typedef logic signed [TS-1:0][DW-1:0] vec_t;
  typedef struct {bit v; bit rel; bit ey; bit ef; bit ed;} row_t;
  logic clk = 0, rst = 1, in_valid = 0, frame_release = 0, rd_en = 0;
  logic in_ready, frame_done, frame_valid;
  logic [AW-1:0] rd_addr = '0;
  vec_t in_vec = '0, rd_vec;
  logic [15:0] frame_cnt;
  int pass = 0, total = 0;
  vec_t q[$];
  int pend = 0, tiles = 0, cnt = 0;
  row_t tbl[4];

  tile_stream_frame_collector #(.TILE_SIZE(TS), .DATA_WIDTH(DW), .D(DD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .frame_done(frame_done), .frame_valid(frame_valid), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_vec(rd_vec), .frame_release(frame_release), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  function automatic vec_t mk(int base);
    vec_t v;
    for (int i = 0; i < TS; i++) v[i] = DW'(base + i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one clock of stimulus; the model tracks complete frames pending and queued tile data
  task automatic cyc(bit v, vec_t vec, bit rel, bit re, int addr);
    bit acc, rdchk, done_e;
    int prev;
    vec_t er;
    in_valid = v; in_vec = vec; frame_release = rel; rd_en = re; rd_addr = AW'(addr);
    acc = v && pend < 2;
    rdchk = re && pend > 0;
    er = rdchk ? q[addr] : '0;
    tick();
    prev = pend;
    done_e = 0;
    if (acc) begin
      q.push_back(vec);
      tiles++;
      if (tiles == NT) begin tiles = 0; pend++; cnt++; done_e = 1; end
    end
    if (rel && prev > 0) begin
      pend--;
      repeat (NT) void'(q.pop_front());
    end
    chk("in_ready", in_ready, pend < 2);
    chk("frame_valid", frame_valid, pend > 0);
    chk("frame_done", frame_done, done_e);
    chk("frame_cnt", frame_cnt, cnt);
    if (rdchk) chk("rd_vec", rd_vec, er);
    in_valid = 0; frame_release = 0; rd_en = 0;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 1; frame_release = 0; rd_en = 0;
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_rd_vec", rd_vec, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst = 0; in_valid = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    q.delete(); pend = 0; tiles = 0; cnt = 0;
  endtask

  task automatic read_all(bit rel_after);
    for (int a = 0; a < NT; a++) cyc(0, '0, 0, 1, a);
    if (rel_after) cyc(0, '0, 1, 0, 0);
  endtask

  initial begin
    int rp, a;
    bit re, rl;
    tbl[0] = '{v: 0, rel: 1, ey: 1, ef: 0, ed: 0};
    tbl[1] = '{v: 0, rel: 1, ey: 1, ef: 0, ed: 0};
    tbl[2] = '{v: 1, rel: 0, ey: 1, ef: 0, ed: 0};
    tbl[3] = '{v: 1, rel: 1, ey: 1, ef: 0, ed: 0};
    repeat (2) tick();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(tbl[k].v, mk(100 + k * 4), tbl[k].rel, 0, 0);
      chk("tbl_ready", in_ready, tbl[k].ey);
      chk("tbl_valid", frame_valid, tbl[k].ef);
      chk("tbl_done", frame_done, tbl[k].ed);
    end
    // single frame, element = tile*4+i
    do_reset();
    for (int t = 0; t < NT; t++) cyc(1, mk(t * 4), 0, 0, 0);
    chk("single_cnt", frame_cnt, 1);
    cyc(0, '0, 0, 0, 0);
    read_all(1);
    // backpressure: two full banks, then one release
    do_reset();
    for (int t = 0; t < 2 * NT; t++) cyc(1, mk(1000 + t * 4), 0, 0, 0);
    chk("bp_ready_low", in_ready, 0);
    repeat (3) cyc(1, mk(9999), 0, 0, 0);
    cyc(1, mk(9999), 1, 0, 0);
    chk("bp_ready_after_rel", in_ready, 1);
    for (int t = 0; t < NT; t++) cyc(1, mk(3000 + t * 4), 0, 1, t);
    chk("bp_refilled", in_ready, 0);
    cyc(0, '0, 1, 0, 0);
    read_all(1);
    chk("bp_cnt", frame_cnt, 3);
    // random input gaps with prompt consumer
    do_reset();
    rp = 0;
    for (int c = 0; c < 6000 && !(cnt == 4 && pend == 0); c++) begin
      re = 0; rl = 0; a = 0;
      if (pend > 0) begin
        if (rp < NT) begin re = 1; a = rp; rp++; end
        else begin rl = 1; rp = 0; end
      end
      cyc(cnt < 4 ? bit'($urandom_range(0, 1)) : 1'b0, mk(int'($urandom)), rl, re, a);
    end
    chk("rand_cnt", frame_cnt, 4);
    chk("rand_drained", pend == 0, 1);
    // final tile into bank 1 together with release of bank 0
    do_reset();
    for (int t = 0; t < 2 * NT - 1; t++) cyc(1, mk(5000 + t * 4), 0, 0, 0);
    cyc(1, mk(5000 + (2 * NT - 1) * 4), 1, 0, 0);
    chk("sim_valid", frame_valid, 1);
    chk("sim_ready", in_ready, 1);
    chk("sim_done", frame_done, 1);
    chk("sim_rd_sel", dut.rd_sel, 1);
    cyc(0, '0, 0, 0, 0);
    read_all(1);
    // reset mid-frame, then a clean frame
    for (int t = 0; t < 30; t++) cyc(1, mk(7000 + t * 4), 0, 0, 0);
    do_reset();
    for (int t = 0; t < NT; t++) cyc(1, mk(8000 + t * 4), 0, 0, 0);
    chk("rst_frame_cnt_after", frame_cnt, 1);
    read_all(1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/tile_stream_frame_collector.md
# tile_stream_frame_collector

Stream-to-frame sink at the back end of the MAC → bias datapath. It accepts `TILE_SIZE`-wide valid/ready tiles, as produced by the bias adder, and assembles `D/TILE_SIZE` consecutive tiles into one `D`-element frame in a ping-pong buffer. On frame completion it issues a one-cycle done pulse to a pulse-driven consumer such as the sigmoid stage. The consumer reads tiles by address and hands the bank back with a release pulse. The block is the stream-to-pulse counterpart of the pulse-to-stream adapter at the MAC output.

## Interface
Parameters:
- `TILE_SIZE`, 4: elements per tile.
- `DATA_WIDTH`, 16: signed element width.
- `D`, 256: elements per frame; must be a multiple of `TILE_SIZE`.
- `NTILE`, `D/TILE_SIZE` (derived, 64): tiles per frame.
- `TA_W`, `$clog2(NTILE)` (derived, 6): tile address width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream tile valid.
- `in_ready` out 1: block can accept a tile.
- `in_vec` in `TILE_SIZE`×`DATA_WIDTH` signed: incoming tile.
- `frame_done` out 1: one-cycle pulse when a frame becomes readable.
- `frame_valid` out 1: level; the read bank holds a complete frame.
- `rd_en` in 1: read request.
- `rd_addr` in `TA_W`: tile index within the read bank.
- `rd_vec` out `TILE_SIZE`×`DATA_WIDTH` signed: read data.
- `frame_release` in 1: consumer has finished with the read bank.
- `frame_cnt` out 16: count of completed frames, wraps at 2^16.

## Operation
- Two banks, 0 and 1, each `NTILE` tiles deep. Each bank has a state of FREE, FILLING or FULL.
- `wr_sel` selects the bank being written. `rd_sel` selects the bank being read. `wr_tile` is a 0..`NTILE-1` counter.
- `in_ready` = !`rst` && state[`wr_sel`] != FULL. It is derived from registers only and never depends on `in_valid`.
- Handshake: a tile is accepted when `in_valid && in_ready`. Accepting a tile:
  - writes `in_vec` to bank[`wr_sel`][`wr_tile`];
  - sets state[`wr_sel`] = FILLING;
  - increments `wr_tile`.
- Tile `NTILE-1` accepted:
  - state[`wr_sel`] → FULL;
  - `wr_tile` → 0;
  - `wr_sel` toggles;
  - `frame_cnt` += 1;
  - `frame_done` is scheduled for the next cycle.
- `frame_valid` = state[`rd_sel`] == FULL.
- `frame_release` while `frame_valid`=1: state[`rd_sel`] → FREE and `rd_sel` toggles.
- `frame_release` while `frame_valid`=0 is ignored with no state change.
- Banks complete and are released strictly in order 0,1,0,1…
- Reads: `rd_en` samples bank[`rd_sel`][`rd_addr`] into `rd_vec`. `rd_vec` holds its value when `rd_en`=0.
- A read while `frame_valid`=0 returns whatever the bank currently contains; the result is not meaningful. It must not corrupt any state.
- Simultaneous events:
  - Final tile into bank X plus release of bank Y≠X in the same cycle: both take effect. On the next cycle X is FULL, Y is FREE, `wr_sel`=Y and `in_ready`=1.
  - `rd_en` plus `frame_release` in the same cycle: the read is served from the bank being released, because the pre-toggle `rd_sel` is used.
- Data is stored unmodified. No arithmetic, saturation or reordering: element i of a tile maps to frame element `tile*TILE_SIZE+i`.
- Reset mid-frame: a partial frame is discarded, both banks return to FREE, and the counters clear. Bank contents need not be cleared.

## Timing
- Reset values with `rst`=1:
  - `in_ready`=0;
  - `frame_done`=0;
  - `frame_valid`=0;
  - `rd_vec`=all 0;
  - `frame_cnt`=0;
  - `wr_sel`=`rd_sel`=0;
  - `wr_tile`=0.
- `in_ready`=1 in the first cycle after `rst` deasserts.
- Write latency: a tile accepted at edge N is readable at the earliest after the frame completes.
- `frame_done` and `frame_valid` rise one cycle after the clock edge that accepts the final tile. `frame_done` is high for exactly one cycle.
- Read latency is 1: with `rd_en` at edge N, `rd_vec` is valid after edge N, in cycle N+1.
- Release → FREE takes one cycle. If the write side was blocked, `in_ready` rises the cycle after the release edge.
- Sustained throughput is one tile per cycle while the consumer releases each frame within `NTILE` cycles of its `frame_done`.
- Back-to-back frames into two free banks need no idle cycle between tile 63 of frame k and tile 0 of frame k+1.

## Test plan
- Single frame, tiles with element value = `tile*4+i`, 64 back-to-back handshakes:
  - `frame_done` pulses once, in the cycle after the 64th accept;
  - reading addresses 0..63 returns identical values at 1-cycle latency;
  - `frame_cnt`=1.
- Backpressure: send 128 tiles with no release:
  - `in_ready` drops after the 128th accept and both banks are FULL;
  - after one release, `in_ready`=1 on the next cycle and bank 0 refills;
  - the second frame's data in bank 1 is intact.
- Random `in_valid` gaps (50%) over 4 frames with prompt releases:
  - frames complete in order 0,1,0,1;
  - every data value matches;
  - `frame_cnt`=4.
- Simultaneous final tile into bank 1 and release of bank 0:
  - next cycle `frame_valid`=1 with `rd_sel`=1;
  - `in_ready`=1;
  - no lost or duplicated `frame_done`.
- Reset asserted after 30 tiles for one cycle:
  - all outputs take their reset values;
  - a new full 64-tile frame completes with correct data and `frame_cnt`=1.
- `frame_release` pulsed while `frame_valid`=0:
  - no change to `rd_sel`, bank state or `in_ready`.
